ps2_scancode_decoder: RTL and testbench

//  Drains the ps2_keyboard byte FIFO (ready/data/nextdata_n) and turns the raw Set-2 byte stream into key events.

---
 rtl/ps2_scancode_decoder.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: drains the ps2_keyboard FIFO and emits key events with ASCII.
// Optional shift tracking (upper case / shifted digit symbols) is enabled by defining PS2DEC_SHIFT_EN.
module ps2_scancode_decoder #(
    parameter int PRESS_CNT_W = 8,
    parameter int PAUSE_SKIP  = 7
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ps2_ready,
    input  logic [7:0]             ps2_data,
    input  logic                   ps2_overflow,
    output logic                   nextdata_n,
    output logic                   key_valid,
    output logic [7:0]             key_code,
    output logic                   key_ext,
    output logic                   key_break,
    output logic                   key_repeat,
    output logic [7:0]             key_ascii,
    output logic [PRESS_CNT_W-1:0] press_cnt,
    output logic                   held_valid,
    output logic                   ovf_err,
    output logic [1:0]             dbg_state
);

    localparam int SKIP_W = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_DEC  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             byte_q, byte_d;
    logic                   nextdata_q, nextdata_d;
    logic                   ext_q, ext_d;
    logic                   brk_q, brk_d;
    logic [SKIP_W-1:0]      skip_q, skip_d;
    logic                   held_valid_q, held_valid_d;
    logic                   held_ext_q, held_ext_d;
    logic [7:0]             held_code_q, held_code_d;
    logic                   key_valid_q, key_valid_d;
    logic [7:0]             key_code_q, key_code_d;
    logic                   key_ext_q, key_ext_d;
    logic                   key_break_q, key_break_d;
    logic                   key_repeat_q, key_repeat_d;
    logic [7:0]             key_ascii_q, key_ascii_d;
    logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   held_match;
`ifdef PS2DEC_SHIFT_EN
    logic                   shift_l_q, shift_l_d;
    logic                   shift_r_q, shift_r_d;
`endif

    // Unshifted Set-2 to ASCII; anything not listed decodes to 00h.
    function automatic logic [7:0] to_ascii(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

`ifdef PS2DEC_SHIFT_EN
    // Shift applied on top of the unshifted character: US layout digit-row symbols.
    function automatic logic [7:0] shift_map(input logic [7:0] a, input logic shift);
        logic [7:0] r;
        r = a;
        if (shift) begin
            if (a >= 8'h61 && a <= 8'h7A) begin
                r = a - 8'h20;
            end else begin
                case (a)
                    8'h30: r = 8'h29; 8'h31: r = 8'h21; 8'h32: r = 8'h40; 8'h33: r = 8'h23;
                    8'h34: r = 8'h24; 8'h35: r = 8'h25; 8'h36: r = 8'h5E; 8'h37: r = 8'h26;
                    8'h38: r = 8'h2A; 8'h39: r = 8'h28;
                    default: r = a;
                endcase
            end
        end
        return r;
    endfunction
`endif

    assign held_match = held_valid_q && (held_ext_q == ext_q) && (held_code_q == byte_q);

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        nextdata_d   = nextdata_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        skip_d       = skip_q;
        held_valid_d = held_valid_q;
        held_ext_d   = held_ext_q;
        held_code_d  = held_code_q;
        key_valid_d  = 1'b0;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_break_d  = key_break_q;
        key_repeat_d = key_repeat_q;
        key_ascii_d  = key_ascii_q;
        press_cnt_d  = press_cnt_q;
        ovf_d        = ovf_q | ps2_overflow;
`ifdef PS2DEC_SHIFT_EN
        shift_l_d    = shift_l_q;
        shift_r_d    = shift_r_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ps2_ready) begin
                    byte_d     = ps2_data;
                    nextdata_d = 1'b0;
                    state_d    = S_POP;
                end
            end
            S_POP: begin
                nextdata_d = 1'b1;
                state_d    = S_DEC;
            end
            S_DEC: begin
                state_d = S_IDLE;
                if (skip_q != '0) begin
                    skip_d = skip_q - 1'b1;
                end else if (byte_q == 8'hE1) begin
                    skip_d = SKIP_W'(PAUSE_SKIP);
                    ext_d  = 1'b0;
                    brk_d  = 1'b0;
                end else if (byte_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (byte_q == 8'hAA || byte_q == 8'hFA || byte_q == 8'hFE ||
                             byte_q == 8'hEE || byte_q == 8'h00 || byte_q == 8'hFF) begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else begin
                    key_valid_d = 1'b1;
                    key_code_d  = byte_q;
                    key_ext_d   = ext_q;
                    key_break_d = brk_q;
`ifdef PS2DEC_SHIFT_EN
                    key_ascii_d = ext_q ? 8'h00 : shift_map(to_ascii(byte_q), shift_l_q | shift_r_q);
                    if (!ext_q && byte_q == 8'h12) shift_l_d = !brk_q;
                    if (!ext_q && byte_q == 8'h59) shift_r_d = !brk_q;
`else
                    key_ascii_d = ext_q ? 8'h00 : to_ascii(byte_q);
`endif
                    if (!brk_q) begin
                        key_repeat_d = held_match;
                        if (!held_match) begin
                            press_cnt_d  = press_cnt_q + 1'b1;
                            held_valid_d = 1'b1;
                            held_ext_d   = ext_q;
                            held_code_d  = byte_q;
                        end
                    end else begin
                        key_repeat_d = 1'b0;
                        if (held_match) held_valid_d = 1'b0;
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            byte_q       <= 8'h00;
            nextdata_q   <= 1'b1;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            skip_q       <= '0;
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= 8'h00;
            key_valid_q  <= 1'b0;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            key_break_q  <= 1'b0;
            key_repeat_q <= 1'b0;
            key_ascii_q  <= 8'h00;
            press_cnt_q  <= '0;
            ovf_q        <= 1'b0;
`ifdef PS2DEC_SHIFT_EN
            shift_l_q    <= 1'b0;
            shift_r_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            nextdata_q   <= nextdata_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            skip_q       <= skip_d;
            held_valid_q <= held_valid_d;
            held_ext_q   <= held_ext_d;
            held_code_q  <= held_code_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_break_q  <= key_break_d;
            key_repeat_q <= key_repeat_d;
            key_ascii_q  <= key_ascii_d;
            press_cnt_q  <= press_cnt_d;
            ovf_q        <= ovf_d;
`ifdef PS2DEC_SHIFT_EN
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
`endif
        end
    end

    assign nextdata_n = nextdata_q;
    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign key_ext    = key_ext_q;
    assign key_break  = key_break_q;
    assign key_repeat = key_repeat_q;
    assign key_ascii  = key_ascii_q;
    assign press_cnt  = press_cnt_q;
    assign held_valid = held_valid_q;
    assign ovf_err    = ovf_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: FIFO model feeds bytes, a reference model predicts events,
// a negedge monitor pops the expected queue on every key_valid. Honours PS2DEC_SHIFT_EN.
module tb_ps2_scancode_decoder;

    localparam int CW = 8;
    localparam int PAUSE_SKIP = 7;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          ps2_ready = 1'b0;
    logic [7:0]    ps2_data = 8'h00;
    logic          ps2_overflow = 1'b0;
    logic          nextdata_n;
    logic          key_valid;
    logic [7:0]    key_code;
    logic          key_ext;
    logic          key_break;
    logic          key_repeat;
    logic [7:0]    key_ascii;
    logic [CW-1:0] press_cnt;
    logic          held_valid;
    logic          ovf_err;
    logic [1:0]    dbg_state;

    ps2_scancode_decoder #(.PRESS_CNT_W(CW), .PAUSE_SKIP(PAUSE_SKIP)) dut (
        .clk(clk), .resetn(resetn), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
        .ps2_overflow(ps2_overflow), .nextdata_n(nextdata_n), .key_valid(key_valid),
        .key_code(key_code), .key_ext(key_ext), .key_break(key_break), .key_repeat(key_repeat),
        .key_ascii(key_ascii), .press_cnt(press_cnt), .held_valid(held_valid),
        .ovf_err(ovf_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [27:0] exp_q[$];   // {code, ext, brk, rep, ascii, press_cnt, held_valid}
    logic [7:0]  fifo_q[$];
    int          pop_cyc_q[$];
    int          cyc = 0;
    int          last_pop = -100;
    bit          prev_low = 1'b0;

    // Reference model state
    bit         m_ext, m_brk, m_held_v, m_held_ext, m_shl, m_shr;
    int         m_skip;
    logic [7:0] m_held_code;
    logic [7:0] m_cnt;

    logic [7:0] letter_codes [0:25] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
        8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [0:9] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46};
    logic [7:0] digit_shift [0:9] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
        8'h2A, 8'h28};
    logic [7:0] key_pool [0:19] = '{8'h1C, 8'h15, 8'h23, 8'h1A, 8'h4D, 8'h35, 8'h45, 8'h16,
        8'h46, 8'h3E, 8'h29, 8'h5A, 8'h66, 8'h75, 8'h0D, 8'h12, 8'h59, 8'h2A, 8'h1E, 8'h6B};
    logic [7:0] drop_pool [0:5] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_ascii(input logic [7:0] b, input bit shift);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == b) return (shift ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == b) return shift ? digit_shift[i] : 8'h30 + 8'(i);
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0D;
        if (b == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held_v = 0; m_held_ext = 0; m_shl = 0; m_shr = 0;
        m_skip = 0; m_held_code = 8'h00; m_cnt = 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit shift, match, rep;
        logic [7:0] asc;
        fifo_q.push_back(b);
        shift = 0;
`ifdef PS2DEC_SHIFT_EN
        shift = m_shl || m_shr;
`endif
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = PAUSE_SKIP; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
            m_ext = 0; m_brk = 0;
        end else begin
            match = m_held_v && m_held_ext == m_ext && m_held_code == b;
            rep = !m_brk && match;
            if (!m_brk && !match) begin
                m_cnt++; m_held_v = 1; m_held_ext = m_ext; m_held_code = b;
            end else if (m_brk && match) begin
                m_held_v = 0;
            end
            asc = m_ext ? 8'h00 : model_ascii(b, shift);
`ifdef PS2DEC_SHIFT_EN
            if (!m_ext && b == 8'h12) m_shl = !m_brk;
            if (!m_ext && b == 8'h59) m_shr = !m_brk;
`endif
            exp_q.push_back({b, m_ext, m_brk, rep, asc, m_cnt, m_held_v});
            m_ext = 0; m_brk = 0;
        end
    endtask

    // FIFO model: the head leaves on the edge where nextdata_n is low.
    always @(negedge clk) begin
        if (resetn && nextdata_n == 1'b0 && fifo_q.size() > 0) void'(fifo_q.pop_front());
        ps2_ready = (fifo_q.size() != 0);
        ps2_data  = ps2_ready ? fifo_q[0] : 8'h00;
    end

    // Monitor: pop timing and event scoreboard.
    always @(negedge clk) begin
        logic [27:0] e;
        cyc++;
        if (!resetn) begin
            prev_low = 0;
            last_pop = -100;
        end else begin
            if (nextdata_n == 1'b0) begin
                check("pop_single_cycle", 32'(prev_low), 0);
                check("pop_spacing_ge3", 32'(cyc - last_pop >= 3), 1);
                last_pop = cyc;
                pop_cyc_q.push_back(cyc);
            end
            prev_low = !nextdata_n;
            if (key_valid) begin
                check("event_latency", 32'(cyc - last_pop), 2);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {4'h0, key_code, key_ext, key_break, key_repeat,
                          key_ascii, press_cnt, held_valid}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("event", {4'h0, key_code, key_ext, key_break, key_repeat, key_ascii,
                          press_cnt, held_valid}, {4'h0, e});
                end
            end
        end
    end

    task automatic wait_drain();
        int quiet = 0;
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && exp_q.size() == 0) quiet++;
            else quiet = 0;
            if (quiet >= 6) done = 1;
        end
        if (!done) check("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    task automatic push_list(input logic [7:0] b[$]);
        foreach (b[i]) push_byte(b[i]);
    endtask

    task automatic check_all_reset(input string name);
        check({name, "_nextdata_n"}, 32'(nextdata_n), 1);
        check({name, "_outputs"}, {2'b00, key_valid, key_code, key_ext, key_break, key_repeat,
              key_ascii, press_cnt, held_valid, ovf_err}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_reset("reset");
        check("reset_state", 32'(dbg_state), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("ovf_initial", 32'(ovf_err), 0);

        // Make then break of 'q'
        push_list('{8'h15, 8'hF0, 8'h15});
        wait_drain();
        check("t1_press_cnt", 32'(press_cnt), 1);
        check("t1_held_valid", 32'(held_valid), 0);

        // Back-to-back bytes with ready held high
        pop_cyc_q.delete();
        push_list('{8'h1C, 8'h32, 8'h21});
        wait_drain();
        check("t2_pop_count", 32'(pop_cyc_q.size()), 3);
        if (pop_cyc_q.size() == 3) begin
            check("t2_gap1", 32'(pop_cyc_q[1] - pop_cyc_q[0]), 3);
            check("t2_gap2", 32'(pop_cyc_q[2] - pop_cyc_q[1]), 3);
        end

        // Typematic, extended keys, ignored bytes, pause sequence
        push_list('{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C});
        push_list('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hAA, 8'hFA});
        push_list('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h23});
        // Dangling prefix carries over to the next key byte
        push_list('{8'hE0, 8'hFE, 8'h1A, 8'hE0, 8'h1A, 8'hF0, 8'hE0, 8'h1A});
`ifdef PS2DEC_SHIFT_EN
        push_list('{8'h12, 8'h15, 8'h16, 8'hF0, 8'h12, 8'h15});
`endif
        wait_drain();
        check("t3_press_cnt", 32'(press_cnt), 32'(m_cnt));

        // Sticky overflow flag
        @(negedge clk) ps2_overflow = 1'b1;
        @(negedge clk) ps2_overflow = 1'b0;
        check("ovf_set", 32'(ovf_err), 1);
        repeat (5) @(negedge clk);
        check("ovf_sticky", 32'(ovf_err), 1);

        // Reset while nextdata_n is low
        push_byte(8'h1C);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (nextdata_n == 1'b0) found = 1;
        end
        check("midpop_seen", 32'(found), 1);
        #1 resetn = 1'b0;
        #1 check_all_reset("midpop_reset");
        fifo_q.delete();
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Randomised byte stream
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 12) push_byte(8'hE0);
            else if (r < 30) push_byte(8'hF0);
            else if (r < 34) push_byte(drop_pool[$urandom_range(0, 5)]);
            else if (r < 36) push_byte(8'hE1);
            else push_byte(key_pool[$urandom_range(0, 19)]);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        wait_drain();
        check("final_press_cnt", 32'(press_cnt), 32'(m_cnt));
        check("final_held_valid", 32'(held_valid), 32'(m_held_v));
        check("leftover_expected", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
